// File: rtl/inst_encoder.sv
// RV32I instruction encoder: turns a decoded request (class, funct fields,
// registers, full-width immediate) into a 32-bit instruction word. The result
// goes into a 2-entry output FIFO. Illegal requests produce a NOP word with
// out_err set. inst_count counts the words the consumer has taken.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] inst_count
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  // Immediate range checks. "Fits in N signed bits" means every bit above
  // bit N-1 is a copy of the sign bit.
  logic i_ok, b_ok, j_ok, u_ok, shamt_ok, is_shift;
  assign i_ok     = (in_imm[31:11] == {21{in_imm[31]}});
  assign b_ok     = (in_imm[31:12] == {20{in_imm[31]}}) && !in_imm[0];
  assign j_ok     = (in_imm[31:20] == {12{in_imm[31]}}) && !in_imm[0];
  assign u_ok     = (in_imm[11:0] == 12'd0);
  assign shamt_ok = (in_imm[31:5] == 27'd0);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  logic [31:0] enc_inst;
  logic        enc_err;

  // Encode the current request. Start from the NOP/err result and override
  // it only when the class is legal and the immediate is in range.
  always_comb begin
    enc_inst = NOP_INST;
    enc_err  = 1'b1;
    case (in_class)
      4'd0: if (u_ok) begin enc_inst = {in_imm[31:12], in_rd, OPC_LUI};   enc_err = 1'b0; end
      4'd1: if (u_ok) begin enc_inst = {in_imm[31:12], in_rd, OPC_AUIPC}; enc_err = 1'b0; end
      4'd2: if (j_ok) begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
        enc_err  = 1'b0;
      end
      4'd3: if (i_ok) begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR};
        enc_err  = 1'b0;
      end
      4'd4: if (b_ok) begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], OPC_BRANCH};
        enc_err  = 1'b0;
      end
      4'd5: if (i_ok) begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
        enc_err  = 1'b0;
      end
      4'd6: if (i_ok) begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
        enc_err  = 1'b0;
      end
      4'd7: begin
        // Shifts carry funct7 and a 5-bit shamt instead of a 12-bit immediate.
        if (is_shift) begin
          if (shamt_ok) begin
            enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM};
            enc_err  = 1'b0;
          end
        end else if (i_ok) begin
          enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM};
          enc_err  = 1'b0;
        end
      end
      4'd8: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
        enc_err  = 1'b0;
      end
      4'd9: if (i_ok) begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_FENCE};
        enc_err  = 1'b0;
      end
      4'd10: if (i_ok) begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_SYSTEM};
        enc_err  = 1'b0;
      end
      default: begin
        enc_inst = NOP_INST;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Two-entry FIFO of {err, inst}. in_ready depends only on registered
  // occupancy, so a full FIFO refuses input even while a pop is happening.
  logic [32:0] mem_reg [2];
  logic        wr_ptr_reg, rd_ptr_reg;
  logic [1:0]  count_reg;
  logic [15:0] inst_count_reg;
  logic        push, pop;

  assign in_ready   = (count_reg != 2'd2);
  assign out_valid  = (count_reg != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_inst   = out_valid ? mem_reg[rd_ptr_reg][31:0] : 32'd0;
  assign out_err    = out_valid ? mem_reg[rd_ptr_reg][32]   : 1'b0;
  assign inst_count = inst_count_reg;

  // FIFO storage, pointers, occupancy and handshake counter. Reset clears
  // everything at once, discarding any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_reg[0]     <= 33'd0;
      mem_reg[1]     <= 33'd0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      count_reg      <= 2'd0;
      inst_count_reg <= 16'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= {enc_err, enc_inst};
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg     <= ~rd_ptr_reg;
        inst_count_reg <= inst_count_reg + 16'd1;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: drivers push expected {err, inst} words
// into a queue when a request is accepted; a monitor compares every word the
// DUT presents against the queue head and pops on each output handshake.
module tb_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] inst_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];
  logic [15:0] exp_count = 16'd0;
  bit          rnd_on = 0;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .inst_count(inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder written from the field tables, using signed arithmetic
  // for range checks and shift/mask arithmetic for field placement.
  function automatic logic [32:0] ref_encode(input logic [3:0] c, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    longint      s;
    logic [31:0] u, w, op, rdv, r1, r2, fn3, fn7;
    bit          ok;
    s   = longint'($signed(imm));
    u   = imm;
    rdv = 32'(rd) << 7;
    r1  = 32'(rs1) << 15;
    r2  = 32'(rs2) << 20;
    fn3 = 32'(f3) << 12;
    fn7 = 32'(f7) << 25;
    ok  = 1'b1;
    w   = 32'd0;
    case (c)
      4'd0, 4'd1: begin
        op = (c == 4'd0) ? 32'h37 : 32'h17;
        ok = (u % 32'd4096) == 0;
        w  = (u & 32'hFFFF_F000) | rdv | op;
      end
      4'd2: begin
        ok = (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (s % 2 == 0);
        w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
             (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | rdv | 32'h6F;
      end
      4'd4: begin
        ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
        w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | r2 | r1 | fn3 |
             (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      4'd6: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((u >> 5) & 32'h7F) << 25) | r2 | r1 | fn3 | ((u & 32'h1F) << 7) | 32'h23;
      end
      4'd8: w = fn7 | r2 | r1 | fn3 | rdv | 32'h33;
      4'd3, 4'd5, 4'd7, 4'd9, 4'd10: begin
        case (c)
          4'd3:    op = 32'h67;
          4'd5:    op = 32'h03;
          4'd7:    op = 32'h13;
          4'd9:    op = 32'h0F;
          default: op = 32'h73;
        endcase
        if (c == 4'd7 && (f3 == 3'd1 || f3 == 3'd5)) begin
          ok = (u <= 32'd31);
          w  = fn7 | (u << 20) | r1 | fn3 | rdv | op;
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w  = ((u & 32'hFFF) << 20) | r1 | fn3 | rdv | op;
        end
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  // Present one request, wait (bounded) for acceptance, then record the
  // expected word. Returns one time unit after the accepting edge.
  task automatic send(input logic [3:0] c, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic [32:0] exp);
    bit ok;
    in_class = c; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for class %0d", c);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin @(negedge clk); k++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every presented word must match the queue head (this also
  // checks that the word is held while the consumer stalls); a handshake pops.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_word: got inst %h err %b with nothing expected", out_inst, out_err);
      end else begin
        check("out_word", {31'd0, out_err, out_inst}, {31'd0, exp_q[0]});
        if (out_ready) begin
          check("inst_count", {48'd0, inst_count}, {48'd0, exp_count});
          $display("pop inst=%h err=%b count=%0d", out_inst, out_err, inst_count);
          void'(exp_q.pop_front());
          exp_count = exp_count + 16'd1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    logic [3:0]  c;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] bnd [12];
    bnd = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
            -32'sd4096, 32'd1048574, -32'sd1048576, 32'd1048576, 32'd31, 32'd32};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_class = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_inst_count", {48'd0, inst_count}, 64'd0);
    check("rst_out_inst", {32'd0, out_inst}, 64'd0);
    check("rst_out_err", {63'd0, out_err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI x1, x0, 5 into an empty FIFO: visible right after the accept edge.
    send(4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, {1'b0, 32'h0050_0093});
    check("latency_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    drain();

    // Known encodings, back to back with the consumer always ready.
    send(4'd8, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h0020_81B3});
    send(4'd8, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h4020_81B3});
    send(4'd6, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, {1'b0, 32'h0020_A423});
    send(4'd2, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, {1'b0, 32'h0080_00EF});
    send(4'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, {1'b0, 32'h1234_52B7});
    drain();

    // Three illegal requests: odd branch offset, out-of-range load, bad class.
    base = exp_count;
    send(4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, {1'b1, 32'h0000_0013});
    send(4'd5, 3'd2, 7'd0, 5'd4, 5'd1, 5'd0, 32'd2048, {1'b1, 32'h0000_0013});
    send(4'd12, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, {1'b1, 32'h0000_0013});
    drain();
    check("err_count_adv", {48'd0, inst_count}, {48'd0, base + 16'd3});

    // Full FIFO: third request must wait even though the consumer is ready.
    out_ready = 1'b0;
    send(4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, {1'b0, 32'h0010_0093});
    send(4'd7, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, {1'b0, 32'h0020_0113});
    out_ready = 1'b1;
    fork
      send(4'd7, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, {1'b0, 32'h0030_0193});
      begin
        @(negedge clk);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check("after_pop_in_ready", {63'd0, in_ready}, 64'd1);
      end
    join
    drain();

    // Randomized traffic with a randomly stalling consumer.
    rnd_on = 1;
    fork
      begin
        for (int n = 0; n < 250; n++) begin
          c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
          case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       imm = bnd[$urandom_range(0, 11)];
            default: imm = $urandom & 32'hFFFF_F000;
          endcase
          f3 = 3'($urandom); f7 = 7'($urandom);
          rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
          send(c, f3, f7, rd, rs1, rs2, imm, ref_encode(c, f3, f7, rd, rs1, rs2, imm));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two buffered words: everything clears at once.
    out_ready = 1'b0;
    send(4'd8, 3'd7, 7'd0, 5'd9, 5'd8, 5'd7, 32'd0, {1'b0, 32'h0074_74B3});
    send(4'd8, 3'd6, 7'd0, 5'd9, 5'd8, 5'd7, 32'd0, {1'b0, 32'h0074_64B3});
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_inst_count", {48'd0, inst_count}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    exp_count = 16'd0;
    out_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    send(4'd10, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd1, {1'b0, 32'h0010_0073});
    drain();
    check("final_inst_count", {48'd0, inst_count}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
